// File: rtl/score_counter.sv
// Purpose: two-digit BCD score counter driven by debounced up/down pulses, with clear and saturate/wrap limits.
// Latency: one clk_1khz edge from the first high cycle of a request to the updated score and flags.
// Backpressure: none; every cycle is sampled and each request pulse yields exactly one event.
module score_counter #(
  parameter int MAX_SCORE = 99,
  parameter bit WRAP_EN   = 1'b0
) (
  input  logic       clk_1khz,
  input  logic       rst_i,
  input  logic       count_up_i,
  input  logic       count_down_i,
  input  logic       clear_i,
  output logic [3:0] score_tens_o,
  output logic [3:0] score_ones_o,
  output logic       at_max_o,
  output logic       at_min_o,
  output logic       changed_o
);

  // Limit held as BCD digits so all score arithmetic stays digit-wise.
  localparam logic [3:0] MAX_TENS = 4'(MAX_SCORE / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_SCORE % 10);

  logic       up_q;
  logic       dn_q;
  logic       up_evt;
  logic       dn_evt;
  logic [3:0] tens_q;
  logic [3:0] ones_q;
  logic [3:0] tens_d;
  logic [3:0] ones_d;
  logic       is_max;
  logic       is_min;

  assign up_evt       = count_up_i & ~up_q;
  assign dn_evt       = count_down_i & ~dn_q;
  assign is_max       = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
  assign is_min       = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign score_tens_o = tens_q;
  assign score_ones_o = ones_q;

  // Next score: clear wins, coincident up/down cancel, otherwise BCD carry/borrow with limit handling.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clear_i) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (up_evt && !dn_evt) begin
      if (is_max) begin
        if (WRAP_EN) begin
          tens_d = 4'd0;
          ones_d = 4'd0;
        end
      end else if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dn_evt && !up_evt) begin
      if (is_min) begin
        if (WRAP_EN) begin
          tens_d = MAX_TENS;
          ones_d = MAX_ONES;
        end
      end else if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  // Register edge-detect history, score digits and the derived flags; edge history resets high
  // so a request already asserted at reset release is ignored until it falls and rises again.
  always_ff @(posedge clk_1khz) begin
    if (rst_i) begin
      up_q      <= 1'b1;
      dn_q      <= 1'b1;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      at_max_o  <= 1'b0;
      at_min_o  <= 1'b1;
      changed_o <= 1'b0;
    end else begin
      up_q      <= count_up_i;
      dn_q      <= count_down_i;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      at_max_o  <= (tens_d == MAX_TENS) && (ones_d == MAX_ONES);
      at_min_o  <= (tens_d == 4'd0) && (ones_d == 4'd0);
      changed_o <= (tens_d != tens_q) || (ones_d != ones_q);
    end
  end

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: three instances (99/saturate, 99/wrap, 15/wrap) share one stimulus.
// A plain-integer score model is compared against every instance each cycle, plus literal spot checks.
module tb_score_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up  = 1'b0;
  logic dn  = 1'b0;
  logic clr = 1'b0;

  logic [3:0] tens [3];
  logic [3:0] ones [3];
  logic       amax [3];
  logic       amin [3];
  logic       chg  [3];

  int checks   = 0;
  int failures = 0;

  int max_s [3] = '{99, 99, 15};
  bit wrap  [3] = '{1'b0, 1'b1, 1'b1};

  // Behavioural model state
  int m_score [3];
  bit m_chg   [3];
  bit m_upq;
  bit m_dnq;
  bit m_valid = 1'b0;

  int chg0_cnt = 0;

  always #5 clk = ~clk;

  score_counter #(.MAX_SCORE(99), .WRAP_EN(1'b0)) u_sat99 (
    .clk_1khz(clk), .rst_i(rst), .count_up_i(up), .count_down_i(dn), .clear_i(clr),
    .score_tens_o(tens[0]), .score_ones_o(ones[0]), .at_max_o(amax[0]), .at_min_o(amin[0]),
    .changed_o(chg[0]));

  score_counter #(.MAX_SCORE(99), .WRAP_EN(1'b1)) u_wrap99 (
    .clk_1khz(clk), .rst_i(rst), .count_up_i(up), .count_down_i(dn), .clear_i(clr),
    .score_tens_o(tens[1]), .score_ones_o(ones[1]), .at_max_o(amax[1]), .at_min_o(amin[1]),
    .changed_o(chg[1]));

  score_counter #(.MAX_SCORE(15), .WRAP_EN(1'b1)) u_wrap15 (
    .clk_1khz(clk), .rst_i(rst), .count_up_i(up), .count_down_i(dn), .clear_i(clr),
    .score_tens_o(tens[2]), .score_ones_o(ones[2]), .at_max_o(amax[2]), .at_min_o(amin[2]),
    .changed_o(chg[2]));

  task automatic check(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: score as an integer, updated from the rules at each rising edge.
  always @(posedge clk) begin
    bit ue;
    bit de;
    int ns;
    ue = up && !m_upq;
    de = dn && !m_dnq;
    for (int i = 0; i < 3; i++) begin
      if (rst || clr)    ns = 0;
      else if (ue && de) ns = m_score[i];
      else if (ue)       ns = (m_score[i] == max_s[i]) ? (wrap[i] ? 0 : max_s[i]) : m_score[i] + 1;
      else if (de)       ns = (m_score[i] == 0) ? (wrap[i] ? max_s[i] : 0) : m_score[i] - 1;
      else               ns = m_score[i];
      m_chg[i]   = !rst && (ns != m_score[i]);
      m_score[i] = ns;
    end
    m_upq = rst ? 1'b1 : up;
    m_dnq = rst ? 1'b1 : dn;
    if (rst) m_valid = 1'b1;
  end

  // Compare every instance against the model on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("i%0d_tens", i), int'(tens[i]), m_score[i] / 10);
        check($sformatf("i%0d_ones", i), int'(ones[i]), m_score[i] % 10);
        check($sformatf("i%0d_at_max", i), int'(amax[i]), int'(m_score[i] == max_s[i]));
        check($sformatf("i%0d_at_min", i), int'(amin[i]), int'(m_score[i] == 0));
        check($sformatf("i%0d_changed", i), int'(chg[i]), int'(m_chg[i]));
      end
    end
  end

  // Count changed_o pulses of the saturating instance, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    if (chg[0]) chg0_cnt = chg0_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit is_up, input int hi, input int lo);
    if (is_up) up = 1'b1; else dn = 1'b1;
    tick(hi);
    up = 1'b0;
    dn = 1'b0;
    tick(lo);
  endtask

  initial begin
    int c0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_tens", int'(tens[0]), 0);
    check("rst_ones", int'(ones[0]), 0);
    check("rst_at_min", int'(amin[0]), 1);
    check("rst_at_max", int'(amax[0]), 0);
    check("rst_changed", int'(chg[0]), 0);

    // Three wide pulses, 20 cycles apart
    c0 = chg0_cnt;
    for (int k = 0; k < 3; k++) pulse(1'b1, 10, 10);
    check("three_up_ones", int'(ones[0]), 3);
    check("three_up_tens", int'(tens[0]), 0);
    check("three_up_chg_pulses", chg0_cnt - c0, 3);

    // BCD carry and borrow across 09/10
    for (int k = 0; k < 6; k++) pulse(1'b1, 2, 2);
    check("at09_ones", int'(ones[0]), 9);
    pulse(1'b1, 2, 2);
    check("carry_tens", int'(tens[0]), 1);
    check("carry_ones", int'(ones[0]), 0);
    pulse(1'b0, 2, 2);
    check("borrow_tens", int'(tens[0]), 0);
    check("borrow_ones", int'(ones[0]), 9);

    // Climb to 99 and test upper limit on both 99 instances
    for (int k = 0; k < 90; k++) pulse(1'b1, 1, 1);
    check("reach99_tens", int'(tens[0]), 9);
    check("reach99_ones", int'(ones[0]), 9);
    c0 = chg0_cnt;
    pulse(1'b1, 1, 2);
    check("sat_up_tens", int'(tens[0]), 9);
    check("sat_up_ones", int'(ones[0]), 9);
    check("sat_up_at_max", int'(amax[0]), 1);
    check("sat_up_no_chg", chg0_cnt - c0, 0);
    check("wrap_up_tens", int'(tens[1]), 0);
    check("wrap_up_ones", int'(ones[1]), 0);

    // Lower limit
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(2);
    c0 = chg0_cnt;
    pulse(1'b0, 1, 2);
    check("sat_dn_ones", int'(ones[0]), 0);
    check("sat_dn_no_chg", chg0_cnt - c0, 0);
    check("wrap_dn_tens", int'(tens[1]), 9);
    check("wrap_dn_ones", int'(ones[1]), 9);

    // Simultaneous up/down, then clear together with up
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    for (int k = 0; k < 5; k++) pulse(1'b1, 1, 1);
    tick(2);
    c0 = chg0_cnt;
    up = 1'b1;
    dn = 1'b1;
    tick(3);
    up = 1'b0;
    dn = 1'b0;
    tick(2);
    check("simul_ones", int'(ones[0]), 5);
    check("simul_no_chg", chg0_cnt - c0, 0);
    c0 = chg0_cnt;
    clr = 1'b1;
    up  = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(3);
    up = 1'b0;
    tick(2);
    check("clr_up_ones", int'(ones[0]), 0);
    check("clr_up_one_chg", chg0_cnt - c0, 1);

    // Request held across reset release is not counted
    up = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    check("held_rst_ones", int'(ones[0]), 0);
    up = 1'b0;
    tick(2);
    pulse(1'b1, 2, 1);
    check("after_rearm_ones", int'(ones[0]), 1);

    // MAX_SCORE=15 wrap instance walk
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    for (int k = 0; k < 15; k++) pulse(1'b1, 1, 1);
    check("m15_tens", int'(tens[2]), 1);
    check("m15_ones", int'(ones[2]), 5);
    check("m15_at_max", int'(amax[2]), 1);
    pulse(1'b1, 1, 1);
    check("m15_wrap_ones", int'(ones[2]), 0);
    check("m15_wrap_at_max", int'(amax[2]), 0);

    // Randomized phase
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) up = ~up;
      if ($urandom_range(0, 4) == 0) dn = ~dn;
      tick(1);
    end
    rst = 1'b0;
    clr = 1'b0;
    up  = 1'b0;
    dn  = 1'b0;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_counter.md
SCORE_COUNTER -- requirements
Module: score_counter

Interface
REQ-001 Parameter MAX_SCORE, default 99: highest score value, legal range 1..99.
REQ-002 Parameter WRAP_EN, default 0: 0 = saturate at the limits, 1 = wrap around at the limits.
REQ-003 clk_1khz  input  1  sole clock, 1 kHz; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 count_up_i  input  1  increment request from the upstream pushbutton stage; synchronous multi-cycle high pulse.
REQ-006 count_down_i  input  1  decrement request from the upstream pushbutton stage; synchronous multi-cycle high pulse.
REQ-007 clear_i  input  1  synchronous level clear of the score.
REQ-008 score_tens_o  output  4  BCD tens digit of the score, 0..9.
REQ-009 score_ones_o  output  4  BCD ones digit of the score, 0..9.
REQ-010 at_max_o  output  1  high while score == MAX_SCORE.
REQ-011 at_min_o  output  1  high while score == 0.
REQ-012 changed_o  output  1  one-cycle pulse whenever the score value changes.

Function
REQ-013 Edge detection: registered copies up_q and dn_q SHALL hold the previous-cycle count_up_i and count_down_i; up_evt = count_up_i & ~up_q, dn_evt = count_down_i & ~dn_q.
REQ-014 Each input pulse SHALL cause exactly one event, regardless of its width (1..N cycles).
REQ-015 Latency: the score outputs SHALL reflect an event on the clock edge that samples the input's first high cycle (one-edge registered latency).
REQ-016 Score SHALL be held internally as two BCD digits; increment and decrement SHALL use BCD carry/borrow (09 -> 10, 10 -> 09); binary-to-BCD conversion SHALL NOT be used.
REQ-017 Priority per cycle: rst_i > clear_i > simultaneous events > single event.
REQ-018 clear_i high: score SHALL become 00 and events in that cycle SHALL be discarded; edge registers SHALL keep tracking the inputs.
REQ-019 up_evt and dn_evt in the same cycle: score SHALL be unchanged and changed_o SHALL stay 0.
REQ-020 up_evt at score == MAX_SCORE: WRAP_EN=0 -> score unchanged; WRAP_EN=1 -> score becomes 00.
REQ-021 dn_evt at score == 0: WRAP_EN=0 -> score unchanged; WRAP_EN=1 -> score becomes MAX_SCORE in BCD.
REQ-022 changed_o SHALL be high for exactly the one cycle following an edge at which the stored score value differs from its prior value; a saturated event or a clear at 00 SHALL NOT pulse it.
REQ-023 at_max_o and at_min_o SHALL be registered and consistent with the score outputs in the same cycle.
REQ-024 Score SHALL never leave the range 0..MAX_SCORE, and each digit SHALL never exceed 9.

Reset
REQ-025 rst_i SHALL set: score = 00, at_min_o = 1, at_max_o = 0, changed_o = 0.
REQ-026 rst_i SHALL set up_q and dn_q to 1, so an input already high when reset releases is not counted until it falls and rises again.
REQ-027 rst_i asserted mid-pulse SHALL abort the pending event; the score after reset SHALL be 00.

Verification
REQ-028 Reset, then three count_up_i pulses 10 cycles wide, spaced 20 cycles apart -> score 03; three changed_o pulses, each 1 cycle wide; at_min_o falls after the first pulse.
REQ-029 Score 09 + up -> tens=1, ones=0; then down -> tens=0, ones=9.
REQ-030 WRAP_EN=0, score 99 + up -> stays 99, at_max_o=1, no changed_o; score 00 + down -> stays 00, no changed_o. WRAP_EN=1 -> 99 + up -> 00; 00 + down -> 99.
REQ-031 Score 05, count_up_i and count_down_i rise on the same cycle -> score 05, changed_o=0; score 05, clear_i and count_up_i rise together -> score 00, changed_o pulses once.
REQ-032 count_up_i held high across rst_i release -> no increment; after it falls and rises again -> score 01.
REQ-033 MAX_SCORE=15, WRAP_EN=1: 16 up pulses from 00 -> 01, …, 15, 00, with at_max_o=1 only while the score is 15.
